// File: rtl/fifo_rr_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rr_scheduler_pkg
// Shared definitions for the FIFO round-robin scheduler and sibling arbiters:
//   - sched_state_e : scheduler FSM states (IDLE, GRANT)
//   - MAX_REQ       : widest requester vector the helper function supports
//   - rr_next_idx   : first requesting index after a pointer, modulo n_req
// -----------------------------------------------------------------------------
package fifo_rr_scheduler_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } sched_state_e;

   localparam int unsigned MAX_REQ = 16;

   // Searches ptr+1, ptr+2, ... (wrapping at n_req) and returns the first
   // index whose req bit is set. Returns 0 when nothing is requesting; the
   // caller qualifies the result with its own "any request" test.
   function automatic logic [3:0] rr_next_idx(
      input logic [MAX_REQ-1:0] req,
      input logic [3:0]         ptr,
      input int unsigned        n_req
   );
      logic [3:0]  idx;
      logic        found;
      int unsigned cand;
      idx   = '0;
      found = 1'b0;
      for (int unsigned k = 1; k <= MAX_REQ; k++) begin
         if (k <= n_req) begin
            cand = (32'(ptr) + k) % n_req;
            if (!found && req[cand[3:0]]) begin
               idx   = cand[3:0];
               found = 1'b1;
            end
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/fifo_rr_scheduler_out_buf.sv
// -----------------------------------------------------------------------------
// sched_out_buf
// Two-entry in-order output buffer holding {data, source index} pairs.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   push, push_data/src : write one entry (ignored only if full and no pop)
//   pop                 : remove head entry (ignored when empty)
//   head_data, head_src : oldest entry
//   count               : number of valid entries (0..2)
// -----------------------------------------------------------------------------
module sched_out_buf
   import fifo_rr_scheduler_pkg::*;
#(
   parameter int D_W   = 32,
   parameter int SRC_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [D_W-1:0]   push_data,
   input  logic [SRC_W-1:0] push_src,
   input  logic             pop,
   output logic [D_W-1:0]   head_data,
   output logic [SRC_W-1:0] head_src,
   output logic [1:0]       count
);

   logic [D_W-1:0]   data_reg [2];
   logic [SRC_W-1:0] src_reg  [2];
   logic             wr_ptr_reg;
   logic             rd_ptr_reg;
   logic [1:0]       count_reg;
   logic [1:0]       count_next;
   logic             pop_ok;
   logic             push_ok;

   assign pop_ok  = pop && (count_reg != 2'd0);
   // A push into a full buffer is accepted when the head leaves in the same cycle.
   assign push_ok = push && ((count_reg != 2'd2) || pop_ok);

   always_comb begin
      count_next = count_reg;
      case ({push_ok, pop_ok})
         2'b10:   count_next = count_reg + 2'd1;
         2'b01:   count_next = count_reg - 2'd1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            data_reg[i] <= '0;
            src_reg[i]  <= '0;
         end
      end else begin
         count_reg <= count_next;
         if (push_ok) begin
            data_reg[wr_ptr_reg] <= push_data;
            src_reg[wr_ptr_reg]  <= push_src;
            wr_ptr_reg           <= ~wr_ptr_reg;
         end
         if (pop_ok) begin
            rd_ptr_reg <= ~rd_ptr_reg;
         end
      end
   end

   assign head_data = data_reg[rd_ptr_reg];
   assign head_src  = src_reg[rd_ptr_reg];
   assign count     = count_reg;

endmodule

// File: rtl/fifo_rr_scheduler.sv
// -----------------------------------------------------------------------------
// fifo_rr_scheduler
// Round-robin burst scheduler draining N_REQ requester FIFOs into a single
// valid/ready stream. A grant lasts up to BURST_LEN reads or until the granted
// FIFO runs empty; the pointer then moves to the last granted index.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   fifo_empty  : empty flag per requester FIFO
//   fifo_dout   : per-FIFO read data, valid the cycle after its read strobe
//   fifo_rd     : one-hot-or-zero read strobe
//   m_data/m_src/m_valid/m_ready : downstream stream (word, source index)
//   busy        : granting, read in flight, or output buffer occupied
// -----------------------------------------------------------------------------
module fifo_rr_scheduler
   import fifo_rr_scheduler_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int D_W       = 32,
   parameter int BURST_LEN = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_REQ-1:0]              fifo_empty,
   input  logic [N_REQ-1:0][D_W-1:0]     fifo_dout,
   output logic [N_REQ-1:0]              fifo_rd,
   output logic signed [D_W-1:0]         m_data,
   output logic [$clog2(N_REQ)-1:0]      m_src,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic                          busy
);

   localparam int         SRC_W     = $clog2(N_REQ);
   localparam logic [0:0] ST_IDLE   = IDLE;
   localparam logic [0:0] ST_GRANT  = GRANT;
   localparam logic [7:0] BURST_MAX = 8'(BURST_LEN);

   logic [0:0]         state_reg,  state_next;
   logic [SRC_W-1:0]   g_reg,      g_next;
   logic [SRC_W-1:0]   ptr_reg,    ptr_next;
   logic [7:0]         burst_cnt_reg, burst_next;
   logic               inflight_reg;
   logic [SRC_W-1:0]   src_d_reg;

   logic [MAX_REQ-1:0] req_vec;
   logic [3:0]         ptr_ext;
   logic [3:0]         pick_idx;
   logic [1:0]         buf_count;
   logic [D_W-1:0]     head_data;
   logic               pop;
   logic [2:0]         occupancy;
   logic               credit_ok;
   logic               rd_en;

   // Round-robin pick over the non-empty FIFOs, starting after ptr.
   always_comb begin
      req_vec              = '0;
      req_vec[N_REQ-1:0]   = ~fifo_empty;
      ptr_ext              = '0;
      ptr_ext[SRC_W-1:0]   = ptr_reg;
      pick_idx             = rr_next_idx(req_vec, ptr_ext, N_REQ);
   end

   // Credit counts buffered words plus the word in flight, net of a pop this
   // cycle, so m_ready reaches fifo_rd combinationally and back-to-back reads
   // are possible while the consumer keeps up. Max occupancy is therefore 2.
   assign pop       = m_valid & m_ready;
   assign occupancy = {1'b0, buf_count} + {2'b00, inflight_reg} - {2'b00, pop};
   assign credit_ok = (occupancy < 3'd2);
   assign rd_en     = (state_reg == ST_GRANT) && !fifo_empty[g_reg] && credit_ok;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rd
      assign fifo_rd[gi] = rd_en && (g_reg == SRC_W'(gi));
   end

   always_comb begin
      state_next = state_reg;
      g_next     = g_reg;
      ptr_next   = ptr_reg;
      burst_next = burst_cnt_reg;
      if (state_reg == ST_IDLE) begin
         if (req_vec != '0) begin
            g_next     = pick_idx[SRC_W-1:0];
            burst_next = '0;
            state_next = ST_GRANT;
         end
      end else begin
         // An empty granted FIFO ends the grant even when credit is short.
         if (fifo_empty[g_reg]) begin
            state_next = ST_IDLE;
            ptr_next   = g_reg;
         end else if (rd_en) begin
            burst_next = burst_cnt_reg + 8'd1;
            if (burst_next == BURST_MAX) begin
               state_next = ST_IDLE;
               ptr_next   = g_reg;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         g_reg         <= '0;
         ptr_reg       <= SRC_W'(N_REQ - 1);
         burst_cnt_reg <= '0;
         inflight_reg  <= 1'b0;
         src_d_reg     <= '0;
      end else begin
         state_reg     <= state_next;
         g_reg         <= g_next;
         ptr_reg       <= ptr_next;
         burst_cnt_reg <= burst_next;
         inflight_reg  <= rd_en;
         if (rd_en) begin
            src_d_reg <= g_reg;
         end
      end
   end

   sched_out_buf #(
      .D_W   (D_W),
      .SRC_W (SRC_W)
   ) u_out_buf (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight_reg),
      .push_data (fifo_dout[src_d_reg]),
      .push_src  (src_d_reg),
      .pop       (pop),
      .head_data (head_data),
      .head_src  (m_src),
      .count     (buf_count)
   );

   assign m_data  = head_data;
   assign m_valid = (buf_count != 2'd0);
   assign busy    = (state_reg == ST_GRANT) || inflight_reg || (buf_count != 2'd0);

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fifo_rr_scheduler
// Bench for fifo_rr_scheduler (N_REQ=4, D_W=32, BURST_LEN=4). Requester FIFOs
// are modelled in the bench; expected word order and grant order come from a
// burst-level round-robin model, independent of the cycle-level credit logic.
// -----------------------------------------------------------------------------
module tb_fifo_rr_scheduler;

   localparam int N     = 4;
   localparam int DW    = 32;
   localparam int BL    = 4;
   localparam int SW    = 2;
   localparam int DEPTH = 64;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [N-1:0]          fifo_empty;
   logic [N-1:0][DW-1:0]  fifo_dout;
   logic [N-1:0]          fifo_rd;
   logic signed [DW-1:0]  m_data;
   logic [SW-1:0]         m_src;
   logic                  m_valid;
   logic                  m_ready = 1'b0;
   logic                  busy;

   always #5 clk = ~clk;

   fifo_rr_scheduler #(.N_REQ(N), .D_W(DW), .BURST_LEN(BL)) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .fifo_rd    (fifo_rd),
      .m_data     (m_data),
      .m_src      (m_src),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .busy       (busy)
   );

   // ---------------- requester FIFO models ----------------
   logic [DW-1:0] fmem [N][DEPTH];
   int            wr_cnt [N];
   int            rd_cnt [N];

   for (genvar gi = 0; gi < N; gi++) begin : g_emp
      assign fifo_empty[gi] = (wr_cnt[gi] == rd_cnt[gi]);
   end

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (rst) begin
            rd_cnt[i]    <= wr_cnt[i];
            fifo_dout[i] <= '0;
         end else if (fifo_rd[i] && (wr_cnt[i] != rd_cnt[i])) begin
            fifo_dout[i] <= fmem[i][rd_cnt[i] % DEPTH];
            rd_cnt[i]    <= rd_cnt[i] + 1;
         end else begin
            fifo_dout[i] <= '0;
         end
      end
   end

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] pend [N][DEPTH];
   int            pend_n [N];
   int            mdl_ptr = N - 1;
   int            mdl_grants [256];
   int            mdl_ng;

   logic [DW-1:0] exp_d [4096];
   int            exp_s [4096];
   int            exp_wr = 0;
   int            exp_rd = 0;

   int obs_grants [256];
   int obs_ng, last_src, run_len, delivered, reads_seen;

   typedef struct {
      logic [N-1:0][7:0] cnt;
      int                pct;
      int                exp_total;
      int                exp_ng;
      logic [31:0]       exp_grants;   // nibble k = k-th granted index
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input longint act, input longint req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   function automatic vec_t mk(input int c0, input int c1, input int c2, input int c3,
                               input int pct, input int total, input int ng,
                               input logic [31:0] gr);
      vec_t v;
      v.cnt[0]     = 8'(c0);
      v.cnt[1]     = 8'(c1);
      v.cnt[2]     = 8'(c2);
      v.cnt[3]     = 8'(c3);
      v.pct        = pct;
      v.exp_total  = total;
      v.exp_ng     = ng;
      v.exp_grants = gr;
      return v;
   endfunction

   task automatic load_word(input int f, input logic [DW-1:0] val);
      fmem[f][wr_cnt[f] % DEPTH] = val;
      wr_cnt[f]++;
      pend[f][pend_n[f]] = val;
      pend_n[f]++;
   endtask

   // Burst-level round robin: next non-empty after ptr, take min(BL, left).
   task automatic plan();
      int left [N];
      int pos  [N];
      int g, take, any;
      mdl_ng = 0;
      for (int i = 0; i < N; i++) begin
         left[i] = pend_n[i];
         pos[i]  = 0;
      end
      any = 1;
      while (any != 0) begin
         any = 0;
         g   = -1;
         for (int k = 1; k <= N; k++) begin
            if (g < 0 && left[(mdl_ptr + k) % N] > 0) g = (mdl_ptr + k) % N;
         end
         if (g >= 0) begin
            any  = 1;
            take = (left[g] < BL) ? left[g] : BL;
            for (int j = 0; j < take; j++) begin
               exp_d[exp_wr] = pend[g][pos[g]];
               exp_s[exp_wr] = g;
               exp_wr++;
               pos[g]++;
            end
            left[g] -= take;
            mdl_grants[mdl_ng] = g;
            mdl_ng++;
            mdl_ptr = g;
         end
      end
      for (int i = 0; i < N; i++) pend_n[i] = 0;
   endtask

   task automatic start_test();
      obs_ng     = 0;
      last_src   = -1;
      run_len    = 0;
      delivered  = 0;
      reads_seen = 0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst     = 1'b0;
      exp_rd  = exp_wr;
      mdl_ptr = N - 1;
      for (int i = 0; i < N; i++) pend_n[i] = 0;
   endtask

   task automatic run_until_drained(input int pct, input string tag);
      int cyc;
      cyc = 0;
      while (!(busy == 1'b0 && fifo_empty == '1 && exp_rd == exp_wr) && cyc < 3000) begin
         @(posedge clk); #1;
         m_ready = ($urandom_range(99) < pct);
         cyc++;
      end
      check({tag, "_drain_in_budget"}, (cyc < 3000), 1);
   endtask

   task automatic monitor();
      logic                 prev_stall;
      logic signed [DW-1:0] prev_d;
      logic [SW-1:0]        prev_s;
      int                   src;
      prev_stall = 1'b0;
      prev_d     = '0;
      prev_s     = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            check("rd_onehot0", ($countones(fifo_rd) <= 1), 1);
            check("rd_to_nonempty_only", |(fifo_rd & fifo_empty), 0);
            check("buf_plus_inflight_le2",
                  (int'(dut.buf_count) + int'(dut.inflight_reg) <= 2), 1);
            if (prev_stall) begin
               check("hold_valid", m_valid, 1);
               check("hold_data", m_data, prev_d);
               check("hold_src", m_src, prev_s);
            end
            if (|fifo_rd) begin
               src = 0;
               for (int i = 0; i < N; i++) if (fifo_rd[i]) src = i;
               reads_seen++;
               if (src != last_src || run_len == BL) begin
                  if (obs_ng < 256) obs_grants[obs_ng] = src;
                  obs_ng++;
                  run_len = 1;
               end else begin
                  run_len++;
               end
               last_src = src;
            end
            if (m_valid && m_ready) begin
               check("word_pending", (exp_rd < exp_wr), 1);
               if (exp_rd < exp_wr) begin
                  check("word_data", m_data, longint'($signed(exp_d[exp_rd])));
                  check("word_src", m_src, exp_s[exp_rd]);
                  exp_rd++;
               end
               delivered++;
            end
            prev_stall = m_valid && !m_ready;
            prev_d     = m_data;
            prev_s     = m_src;
         end
      end
   endtask

   // Per-cycle expectations for three words 5,-7,9 in FIFO0, loaded in IDLE cycle t.
   int exp_a_rd    [7] = '{0, 1, 1, 1, 0, 0, 0};
   int exp_a_valid [7] = '{0, 0, 0, 1, 1, 1, 0};
   int exp_a_data  [7] = '{0, 0, 0, 5, -7, 9, 0};

   initial begin
      int            base, first_word, cyc, ng;
      logic [DW-1:0] w;

      fork
         monitor();
      join_none

      vecs[0] = mk(3, 0, 0, 0, 100,  3, 1, 32'h0000_0000);
      vecs[1] = mk(8, 8, 8, 8, 100, 32, 8, 32'h3210_3210);
      vecs[2] = mk(0, 2, 0, 3, 100,  5, 2, 32'h0000_0031);
      vecs[3] = mk(0, 0, 10, 0, 50, 10, 3, 32'h0000_0222);
      vecs[4] = mk(5, 0, 0, 6, 100, 11, 4, 32'h0000_3030);
      vecs[5] = mk(0, 0, 0, 0, 100,  0, 0, 32'h0000_0000);
      vecs[6] = mk(1, 1, 1, 1,  30,  4, 4, 32'h0000_3210);

      // ---- reset state ----
      start_test();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_fifo_rd", fifo_rd, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_m_src", m_src, 0);
      check("rst_busy", busy, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_m_valid", m_valid, 0);
      check("post_rst_busy", busy, 0);
      check("post_rst_fifo_rd", fifo_rd, 0);

      // ---- table-driven scenarios ----
      for (int v = 0; v < 7; v++) begin
         do_reset();
         start_test();
         base = exp_wr;
         for (int i = 0; i < N; i++)
            for (int j = 0; j < int'(vecs[v].cnt[i]); j++)
               load_word(i, $urandom);
         plan();
         check("vec_model_total", exp_wr - base, vecs[v].exp_total);
         run_until_drained(vecs[v].pct, "vec");
         check("vec_delivered", delivered, vecs[v].exp_total);
         check("vec_reads", reads_seen, vecs[v].exp_total);
         check("vec_grant_count", obs_ng, vecs[v].exp_ng);
         for (int k = 0; k < vecs[v].exp_ng && k < obs_ng; k++) begin
            ng = int'(vecs[v].exp_grants[4*k +: 4]);
            check("vec_grant_order", obs_grants[k], ng);
         end
         check("vec_busy_end", busy, 0);
         $display("vec %0d: %0d words delivered, %0d grants", v, delivered, obs_ng);
      end

      // ---- three words 5,-7,9 in FIFO0: latency, back-to-back reads, busy fall ----
      do_reset();
      start_test();
      m_ready = 1'b1;
      load_word(0, 32'd5);
      load_word(0, 32'hFFFF_FFF9);
      load_word(0, 32'd9);
      plan();
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         check("seq3_fifo_rd", fifo_rd, (exp_a_rd[k] != 0) ? 1 : 0);
         check("seq3_m_valid", m_valid, exp_a_valid[k]);
         if (exp_a_valid[k] != 0) begin
            check("seq3_m_data", m_data, exp_a_data[k]);
            check("seq3_m_src", m_src, 0);
         end
      end
      check("seq3_busy_fell", busy, 0);
      $display("seq3: %0d words delivered", delivered);

      // ---- back-pressure: FIFO2 holds 10, m_ready low for 20 cycles ----
      do_reset();
      start_test();
      m_ready = 1'b0;
      for (int j = 0; j < 10; j++) begin
         w = $urandom;
         if (j == 0) first_word = int'(w);
         load_word(2, w);
      end
      plan();
      repeat (20) begin
         @(posedge clk); #1;
      end
      check("stall_reads", reads_seen, 2);
      check("stall_m_valid", m_valid, 1);
      check("stall_m_data", m_data, longint'(first_word));
      run_until_drained(100, "stall");
      check("stall_delivered", delivered, 10);
      $display("stall: %0d reads during stall window, %0d words delivered", 2, delivered);

      // ---- reset one cycle after the 2nd read of a burst ----
      do_reset();
      start_test();
      m_ready = 1'b1;
      for (int j = 0; j < 8; j++) load_word(0, $urandom);
      plan();
      cyc = 0;
      while (reads_seen < 2 && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("midrst_reached_2nd_read", (cyc < 50), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst     = 1'b0;
      exp_rd  = exp_wr;
      mdl_ptr = N - 1;
      @(negedge clk);
      check("midrst_m_valid", m_valid, 0);
      check("midrst_fifo_rd", fifo_rd, 0);
      check("midrst_busy", busy, 0);
      check("midrst_state_idle", dut.state_reg, 0);
      check("midrst_ptr", dut.ptr_reg, N - 1);
      @(posedge clk); #1;
      start_test();
      for (int i = 0; i < N; i++) load_word(i, $urandom);
      plan();
      run_until_drained(100, "midrst_after");
      check("midrst_first_grant", obs_grants[0], 0);
      check("midrst_after_delivered", delivered, 4);
      $display("midrst: post-reset first grant %0d, %0d words", obs_grants[0], delivered);

      // ---- randomized rounds against the burst-level model ----
      for (int r = 0; r < 30; r++) begin
         start_test();
         base = exp_wr;
         for (int i = 0; i < N; i++) begin
            ng = $urandom_range(9);
            for (int j = 0; j < ng; j++) load_word(i, $urandom);
         end
         plan();
         run_until_drained($urandom_range(100, 20), "rand");
         check("rand_delivered", delivered, exp_wr - base);
         check("rand_grant_count", obs_ng, mdl_ng);
         for (int k = 0; k < mdl_ng && k < obs_ng; k++)
            check("rand_grant_order", obs_grants[k], mdl_grants[k]);
         $display("rand %0d: %0d words, %0d grants", r, delivered, obs_ng);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_rr_scheduler.md
FIFO_RR_SCHEDULER -- requirements
Module: fifo_rr_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, number of requester FIFOs (2..16).
REQ-002 Parameter D_W, default 32, data width of each FIFO and of the output.
REQ-003 Parameter BURST_LEN, default 4, maximum reads per grant before rotation (1..255).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 fifo_empty  input  N_REQ  empty flag of each requester FIFO.
REQ-007 fifo_dout  input  N_REQ x D_W signed  data_out of each FIFO; valid the cycle after its read strobe, zero otherwise.
REQ-008 fifo_rd  output  N_REQ  one-hot-or-zero read strobe to each FIFO.
REQ-009 m_data  output  D_W signed  head word to downstream consumer.
REQ-010 m_src  output  clog2(N_REQ)  index of the FIFO that supplied m_data.
REQ-011 m_valid  output  1  m_data/m_src valid.
REQ-012 m_ready  input  1  consumer accepts word when m_valid and m_ready are both high.
REQ-013 busy  output  1  high when the state is GRANT, a read is in flight, or the output buffer is non-empty.

Function
REQ-014 States IDLE and GRANT; grant index g and round-robin pointer ptr are registered.
REQ-015 IDLE: when any fifo_empty bit is low, g SHALL be loaded with the first non-empty index searching ptr+1, ptr+2, ... modulo N_REQ; the state moves to GRANT and the burst counter clears; otherwise the state stays IDLE.
REQ-016 GRANT: fifo_rd[g] SHALL be high, combinationally, iff fifo_empty[g]=0 and credit_ok; all other fifo_rd bits are 0 in every state.
REQ-017 credit_ok = (buf_count + inflight - pop) < 2, where pop = m_valid & m_ready; this is a combinational path from m_ready to fifo_rd.
REQ-018 Each issued read increments the burst counter.
REQ-019 GRANT -> IDLE with ptr<=g when the read making the count equal BURST_LEN is issued.
REQ-020 GRANT -> IDLE with ptr<=g when fifo_empty[g]=1 in a GRANT cycle; this takes priority regardless of credit.
REQ-021 A read issued in cycle t sets inflight and src_d<=g; in cycle t+1, fifo_dout[src_d] and src_d SHALL be written into the 2-entry output buffer.
REQ-022 Output buffer is in-order; m_valid = (buf_count != 0); m_data/m_src come from the head entry.
REQ-023 Simultaneous capture and pop keep buf_count unchanged and preserve order; overflow is impossible by REQ-017.
REQ-024 Latency: with an idle scheduler and m_ready=1, a FIFO seen non-empty in IDLE cycle t yields fifo_rd at t+1 and m_valid at t+3.
REQ-025 Throughput: one word per cycle sustained within a burst while m_ready=1.
REQ-026 fifo_rd is never asserted to an empty FIFO.

Reset
REQ-027 On rst: state=IDLE, ptr=N_REQ-1 (requester 0 has first priority), g=0, burst counter=0, inflight=0, buf_count=0.
REQ-028 During and immediately after reset: fifo_rd=0, m_valid=0, m_data=0, m_src=0, busy=0.
REQ-029 Reset mid-burst discards in-flight and buffered words; the requester FIFOs are reset by the same rst.

Structure
REQ-030 Shared package holds the state enum (IDLE, GRANT) and a round-robin next-index function used by other arbiters.
REQ-031 The 2-entry output buffer is a sub-module, sched_out_buf, with ports push/data/src in, pop, head data/src, and count.

Verification
REQ-032 FIFO0 holds 3 words (5,-7,9), others empty, m_ready=1 -> fifo_rd[0] high for 3 consecutive cycles; m_data 5,-7,9 with m_src=0; busy then falls.
REQ-033 All 4 FIFOs hold 8 words, BURST_LEN=4, m_ready=1 -> grant order 0,1,2,3,0,1,2,3; bursts of 4 reads; 32 words delivered with no loss.
REQ-034 FIFO2 holds 10 words, m_ready=0 for 20 cycles -> exactly 2 reads issued, m_valid held, m_data stable; on release, all 10 words delivered in order.
REQ-035 FIFO1 holds 2 words, BURST_LEN=4 -> 2 reads, then IDLE; next grant goes to the next non-empty index after 1.
REQ-036 rst asserted one cycle after the 2nd read of a burst -> next cycle m_valid=0, fifo_rd=0, state IDLE, ptr=N_REQ-1.
REQ-037 Assertions held in every scenario: fifo_rd one-hot-or-zero; fifo_rd[i] implies !fifo_empty[i]; buf_count+inflight <= 2.
